// File: rtl/multiport_regfile.sv
// Multi-read, single-write register file with byte enables and a per-entry pending
// scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module multiport_regfile #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [2**ADDR_W-1:0]     pend_vec
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             pend_q, pend_d;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_a;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_a;
    logic [NUM_RD-1:0]             rd_busy_a;
    logic                          wr_ok;

    assign rd_a     = rd_addr;
    assign rd_data  = rd_data_a;
    assign rd_busy  = rd_busy_a;
    assign pend_vec = pend_q;
    assign wr_ok    = wr_en && !(ZERO_R0 != 0 && wr_addr == '0);

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem_d[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        // Clear for the completing write first so a same-cycle new producer wins.
        if (wr_en)  pend_d[wr_addr] = 1'b0;
        if (sb_set) pend_d[sb_addr] = 1'b1;
        if (flush)  pend_d = '0;
        if (ZERO_R0 != 0) begin
            mem_d[0]  = '0;
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] wr_merge;
    always_comb begin
        wr_merge = mem_q[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) wr_merge[8*b +: 8] = wr_data[8*b +: 8];
        end
    end
`endif

    always_comb begin
        rd_data_a = '0;
        rd_busy_a = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data_a[p] = mem_q[rd_a[p]];
            rd_busy_a[p] = pend_q[rd_a[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && wr_addr == rd_a[p]) begin
                rd_data_a[p] = wr_merge;
                rd_busy_a[p] = sb_set && !flush && sb_addr == rd_a[p];
            end
`endif
            if (rst) begin
                rd_data_a[p] = '0;
                rd_busy_a[p] = 1'b0;
            end
        end
    end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: register width in bits; must be a multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter NUM_RD, default 2: number of combinational read ports, range 1..4.
REQ-004 SHALL provide parameter ZERO_R0, default 0: when 1, entry 0 is hardwired to zero.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-009 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 SHALL have port wr_be, input, DATA_W/8 bits: byte enables; bit k gates byte [8k+7:8k].
REQ-011 SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: packed read addresses; port p occupies slice p.
REQ-012 SHALL have port rd_data, output, NUM_RD*DATA_W bits: packed read data, same slice order as rd_addr.
REQ-013 SHALL have port sb_set, input, 1 bit: marks sb_addr as pending (producer issued).
REQ-014 SHALL have port sb_addr, input, ADDR_W bits: scoreboard set address.
REQ-015 SHALL have port flush, input, 1 bit: clears all pending bits.
REQ-016 SHALL have port rd_busy, output, NUM_RD bits: bit p = 1 when read port p addresses a pending entry.
REQ-017 SHALL have port pend_vec, output, DEPTH bits: registered pending bit per entry.

Function
REQ-018 Write: on a clk edge with wr_en=1, only bytes whose wr_be bit is 1 SHALL be updated; other bytes hold.
REQ-019 wr_en=1 with wr_be all zero SHALL leave data unchanged but SHALL still clear the pending bit.
REQ-020 Read: rd_data slice p SHALL equal the stored entry at rd_addr slice p, combinationally, zero-cycle latency.
REQ-021 Scoreboard: sb_set=1 SHALL set pend_vec[sb_addr] at the clk edge.
REQ-022 Any write (wr_en=1) SHALL clear pend_vec[wr_addr] at the same edge.
REQ-023 Simultaneous sb_set and write to the same address SHALL leave the pending bit set (new producer wins).
REQ-024 flush=1 SHALL clear all pend_vec bits at the edge and SHALL override sb_set in that cycle; data writes still occur.
REQ-025 rd_busy[p] SHALL equal pend_vec[rd_addr slice p], except as modified by REQ-031.
REQ-026 ZERO_R0=1: entry 0 SHALL read 0, writes to 0 SHALL be ignored, and pend_vec[0] SHALL stay 0.
REQ-027 Multiple read ports addressing the same entry SHALL all return identical data.

Reset
REQ-028 rst=1 SHALL asynchronously clear every entry to 0 and every pend_vec bit to 0.
REQ-029 While rst=1, writes, sb_set and flush SHALL be ignored; rd_data SHALL read 0 and rd_busy SHALL be 0.
REQ-030 rst asserted mid-sequence (e.g. with a set pending) SHALL discard all state; there is no recovery of prior values.

Configuration
REQ-031 With macro REGFILE_BYPASS_EN defined: when wr_en=1 and wr_addr equals rd_addr slice p, rd_data slice p SHALL return the byte-merged result of wr_data over the stored value, and rd_busy[p] SHALL be 0 unless sb_set to the same address is also active. Without the macro, reads SHALL return stored values only, and rd_busy SHALL follow REQ-025 directly.

Verification
REQ-032 Reset, then write 0xABCD to entry 5 with wr_be=11; next cycle rd_addr port0=5 -> rd_data0=0xABCD.
REQ-033 Entry 2 holds 0x1234; write 0xFF00 with wr_be=10 -> entry 2 reads 0xFF34.
REQ-034 sb_set addr 4 -> pend_vec[4]=1 and rd_busy[0]=1 with rd_addr0=4; write entry 4 -> pend_vec[4]=0 after the edge. Then sb_set and write both to entry 4 in one cycle -> pend_vec[4]=1.
REQ-035 Set entries 1, 3 and 6 pending; flush together with sb_set on entry 7 -> pend_vec=0.
REQ-036 With REGFILE_BYPASS_EN: entry 3 holds 0x0008; write 0x00AA with wr_be=01 while rd_addr1=3, same cycle -> rd_data1=0x00AA. Without the macro -> rd_data1=0x0008 until after the edge.
REQ-037 ZERO_R0=1: write 0x5555 to entry 0 -> reads 0. Separately, assert rst asynchronously mid-cycle with data present -> all reads immediately 0.
